// File: rtl/sha_256_arbiter_pkg.sv
// Shared types and sizes for the two-requester SHA-256 core arbiter.
package sha_256_arbiter_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  localparam int unsigned BLOCK_W         = 512;
  localparam int unsigned DIGEST_W        = 256;
  localparam int unsigned TIMEOUT_CYC_DEF = 4096;

endpackage

// File: rtl/sha_256_rr_pick.sv
// Two-way round-robin pick: a lone request wins outright, a tie goes to ptr.
module sha_256_rr_pick (
  input  logic [1:0] req,
  input  logic       ptr,
  output logic [1:0] grant
);

  always_comb begin
    grant = req;
    if (&req) grant = ptr ? 2'b10 : 2'b01;
  end

endmodule

// File: rtl/sha_256_arbiter.sv
// Shares one SHA-256 core between two requesters; a multi-block message keeps
// the core locked to its owner until the last block or an idle timeout.
module sha_256_arbiter
  import sha_256_arbiter_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic                i_Clk,
  input  logic                i_Rst,
  input  logic [1:0]          i_fReq,
  input  logic [1:0]          i_fLast,
  input  logic [BLOCK_W-1:0]  i_Text0,
  input  logic [BLOCK_W-1:0]  i_Text1,
  output logic [1:0]          o_fAck,
  output logic [1:0]          o_fDone,
  output logic [1:0]          o_fAbort,
  output logic [DIGEST_W-1:0] o_Digest,
  output logic [1:0]          o_Grant,
  output logic                o_Core_fStart,
  output logic                o_Core_fInit,
  output logic [BLOCK_W-1:0]  o_Core_Text,
  input  logic                i_Core_fDone,
  input  logic [DIGEST_W-1:0] i_Core_Text
);

  localparam int unsigned      TMR_W    = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYC - 1);

  state_t             state;
  logic               ptr;
  logic               last_q;
  logic [TMR_W-1:0]   tmr;
  logic [1:0]         pick;
  logic [1:0]         who;
  logic [1:0]         own_req;
  logic [BLOCK_W-1:0] sel_text;
  logic               sel_last;

  sha_256_rr_pick u_pick (
    .req   (i_fReq),
    .ptr   (ptr),
    .grant (pick)
  );

  // Outside IDLE the block source is always the current owner.
  always_comb begin
    who      = (state == S_IDLE) ? pick : o_Grant;
    own_req  = i_fReq & o_Grant;
    sel_text = who[1] ? i_Text1 : i_Text0;
    sel_last = |(i_fLast & who);
  end

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      state         <= S_IDLE;
      ptr           <= 1'b0;
      last_q        <= 1'b0;
      tmr           <= '0;
      o_fAck        <= '0;
      o_fDone       <= '0;
      o_fAbort      <= '0;
      o_Digest      <= '0;
      o_Grant       <= '0;
      o_Core_fStart <= 1'b0;
      o_Core_fInit  <= 1'b0;
      o_Core_Text   <= '0;
    end else begin
      o_fAck   <= '0;
      o_fDone  <= '0;
      o_fAbort <= '0;
      case (state)
        S_IDLE: begin
          if (|i_fReq) begin
            o_Grant       <= pick;
            o_fAck        <= pick;
            o_Core_Text   <= sel_text;
            last_q        <= sel_last;
            o_Core_fInit  <= 1'b1;
            o_Core_fStart <= 1'b1;
            state         <= S_RUN;
          end
        end
        S_RUN: begin
          if (i_Core_fDone) begin
            o_Digest      <= i_Core_Text;
            o_fDone       <= o_Grant;
            o_Core_fStart <= 1'b0;
            tmr           <= '0;
            if (last_q) begin
              o_Grant <= '0;
              ptr     <= ~o_Grant[1];
              state   <= S_IDLE;
            end else begin
              state <= S_HOLD;
            end
          end
        end
        S_HOLD: begin
          // An owner request in the timeout cycle still wins over the abort.
          if (|own_req) begin
            o_fAck        <= o_Grant;
            o_Core_Text   <= sel_text;
            last_q        <= sel_last;
            o_Core_fInit  <= 1'b0;
            o_Core_fStart <= 1'b1;
            state         <= S_RUN;
          end else if (tmr == TMR_LAST) begin
            o_fAbort <= o_Grant;
            o_Grant  <= '0;
            ptr      <= ~o_Grant[1];
            state    <= S_IDLE;
          end else begin
            tmr <= tmr + 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sha_256_arbiter.sv
// Directed bench for sha_256_arbiter with a behavioural core and pulse scoreboards.
module tb_sha_256_arbiter;

  logic         i_Clk = 1'b0;
  logic         i_Rst;
  logic [1:0]   i_fReq, i_fLast;
  logic [511:0] i_Text0, i_Text1;
  logic [1:0]   o_fAck, o_fDone, o_fAbort, o_Grant;
  logic [255:0] o_Digest;
  logic         o_Core_fStart, o_Core_fInit;
  logic [511:0] o_Core_Text;
  logic         i_Core_fDone;
  logic [255:0] i_Core_Text;

  sha_256_arbiter #(.TIMEOUT_CYC(16)) dut (
    .i_Clk(i_Clk), .i_Rst(i_Rst), .i_fReq(i_fReq), .i_fLast(i_fLast),
    .i_Text0(i_Text0), .i_Text1(i_Text1), .o_fAck(o_fAck), .o_fDone(o_fDone),
    .o_fAbort(o_fAbort), .o_Digest(o_Digest), .o_Grant(o_Grant),
    .o_Core_fStart(o_Core_fStart), .o_Core_fInit(o_Core_fInit),
    .o_Core_Text(o_Core_Text), .i_Core_fDone(i_Core_fDone), .i_Core_Text(i_Core_Text)
  );

  always #5 i_Clk = ~i_Clk;

  localparam logic [511:0] ABC     = {32'h61626380, 448'h0, 32'h00000018};
  localparam logic [255:0] ABC_DIG =
    256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct { int who; logic [255:0] dig; } done_t;
  int    ack_q[$];
  int    abort_q[$];
  done_t done_q[$];

  function automatic logic [255:0] dig_of(input logic [511:0] t);
    if (t == ABC) return ABC_DIG;
    return t[511:256] ^ t[255:0] ^ {8{32'h9e3779b9}};
  endfunction

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Behavioural core: latches text on a fresh start, answers after core_lat cycles.
  int           core_lat = 8;
  int           cnt;
  logic         busy, fs_q, core_done, spur = 1'b0;
  logic [511:0] tlat;
  logic [255:0] core_dig;

  assign i_Core_fDone = core_done | spur;
  assign i_Core_Text  = core_dig;

  always @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      busy <= 1'b0; cnt <= 0; core_done <= 1'b0; fs_q <= 1'b0;
      core_dig <= '0; tlat <= '0;
    end else begin
      core_done <= 1'b0;
      fs_q      <= o_Core_fStart;
      if (!busy) begin
        if (o_Core_fStart && !fs_q) begin
          busy <= 1'b1; cnt <= 1; tlat <= o_Core_Text;
        end
      end else if (cnt >= core_lat) begin
        core_done <= 1'b1; core_dig <= dig_of(tlat); busy <= 1'b0;
      end else begin
        cnt <= cnt + 1;
      end
    end
  end

  int    m_who;
  done_t m_d;
  always @(negedge i_Clk) begin
    if (!i_Rst) begin
      if (busy) begin
        chk("run_text_stable", o_Core_Text, tlat);
        chk("run_fstart", o_Core_fStart, 1'b1);
      end
      if (o_fAck != 2'b00) begin
        if (ack_q.size() == 0) chk("ack_unexpected", o_fAck, 2'b00);
        else begin
          m_who = ack_q.pop_front();
          chk("ack_who", o_fAck, 2'b01 << m_who);
          chk("ack_grant", o_Grant, 2'b01 << m_who);
        end
      end
      if (o_fDone != 2'b00) begin
        if (done_q.size() == 0) chk("done_unexpected", o_fDone, 2'b00);
        else begin
          m_d = done_q.pop_front();
          chk("done_who", o_fDone, 2'b01 << m_d.who);
          chk("done_digest", o_Digest, m_d.dig);
          chk("done_fstart", o_Core_fStart, 1'b0);
        end
      end
      if (o_fAbort != 2'b00) begin
        if (abort_q.size() == 0) chk("abort_unexpected", o_fAbort, 2'b00);
        else begin
          m_who = abort_q.pop_front();
          chk("abort_who", o_fAbort, 2'b01 << m_who);
        end
      end
    end
  end

  task automatic raise(input int idx, input logic last, input logic [511:0] t);
    i_fReq[idx]  = 1'b1;
    i_fLast[idx] = last;
    if (idx == 0) i_Text0 = t; else i_Text1 = t;
  endtask

  task automatic wait_ack(input int idx, output int cyc);
    cyc = 0;
    do begin @(negedge i_Clk); cyc++; end while (!o_fAck[idx] && cyc < 400);
    chk($sformatf("ack%0d_seen", idx), o_fAck[idx], 1'b1);
    i_fReq[idx] = 1'b0;
  endtask

  task automatic wait_done(input int idx);
    int c = 0;
    do begin @(negedge i_Clk); c++; end while (!o_fDone[idx] && c < 400);
    chk($sformatf("done%0d_seen", idx), o_fDone[idx], 1'b1);
  endtask

  task automatic do_reset();
    i_Rst = 1'b1;
    repeat (2) @(negedge i_Clk);
    i_Rst = 1'b0;
  endtask

  task automatic push_blk(input int idx, input logic [511:0] t);
    ack_q.push_back(idx);
    done_q.push_back('{who: idx, dig: dig_of(t)});
  endtask

  int c;
  logic [511:0] t_a = {16{32'ha0a0_0001}}, t_b = {16{32'hb1b1_0002}},
                t_c = {16{32'hc2c2_0003}}, t_d = {16{32'hd3d3_0004}},
                t_e = {16{32'he4e4_0005}}, t_f = {16{32'hf5f5_0006}},
                t_g = {16{32'h1616_0007}}, t_h = {16{32'h2727_0008}},
                t_i = {16{32'h3838_0009}}, t_j = {16{32'h4949_000a}},
                t_k = {16{32'h5a5a_000b}}, t_l = {16{32'h6b6b_000c}},
                t_m = {16{32'h7c7c_000d}};

  initial begin
    i_Rst = 1'b1; i_fReq = '0; i_fLast = '0; i_Text0 = '0; i_Text1 = '0;
    repeat (2) @(negedge i_Clk);
    chk("rst_ctrl", {o_Grant, o_fAck, o_fDone, o_fAbort, o_Core_fStart, o_Core_fInit}, '0);
    chk("rst_digest", o_Digest, '0);
    chk("rst_text", o_Core_Text, '0);
    i_Rst = 1'b0;
    @(negedge i_Clk);

    // "abc" single block, slow core
    core_lat = 70;
    push_blk(0, ABC);
    raise(0, 1'b1, ABC);
    wait_ack(0, c);
    chk("abc_ack_latency", c, 1);
    chk("abc_finit", o_Core_fInit, 1'b1);
    chk("abc_text", o_Core_Text, ABC);
    wait_done(0);
    chk("abc_idle_grant", o_Grant, 2'b00);
    repeat (3) @(negedge i_Clk);
    chk("abc_digest_held", o_Digest, ABC_DIG);

    // stray core done while idle
    spur = 1'b1;
    @(negedge i_Clk);
    spur = 1'b0;
    @(negedge i_Clk);
    chk("spur_no_done", o_fDone, 2'b00);
    chk("spur_digest", o_Digest, ABC_DIG);
    chk("spur_no_grant", o_Grant, 2'b00);

    // simultaneous requests from reset, then a tie that favours requester 1
    core_lat = 8;
    do_reset();
    push_blk(0, t_a); push_blk(1, t_b); push_blk(0, t_c);
    raise(0, 1'b1, t_a); raise(1, 1'b1, t_b);
    wait_ack(0, c);
    wait_done(0);
    raise(0, 1'b1, t_c);
    wait_ack(1, c);
    chk("rr_first_tie_lat", c, 1);
    wait_done(1);
    wait_ack(0, c);
    wait_done(0);

    // two-block message while requester 1 waits
    push_blk(1, t_d); push_blk(0, t_e); push_blk(0, t_g); push_blk(1, t_f);
    raise(1, 1'b1, t_d);
    wait_ack(1, c);
    wait_done(1);
    raise(0, 1'b0, t_e); raise(1, 1'b1, t_f);
    wait_ack(0, c);
    chk("msg_finit1", o_Core_fInit, 1'b1);
    wait_done(0);
    repeat (3) begin
      chk("hold_grant", o_Grant, 2'b01);
      @(negedge i_Clk);
    end
    raise(0, 1'b1, t_g);
    wait_ack(0, c);
    chk("msg_finit0", o_Core_fInit, 1'b0);
    chk("msg_grant", o_Grant, 2'b01);
    wait_done(0);
    chk("msg_end_grant", o_Grant, 2'b00);
    wait_ack(1, c);
    chk("msg_req1_finit", o_Core_fInit, 1'b1);
    wait_done(1);

    // owner goes silent in HOLD
    ack_q.push_back(0);
    done_q.push_back('{who: 0, dig: dig_of(t_h)});
    abort_q.push_back(0);
    raise(0, 1'b0, t_h);
    wait_ack(0, c);
    wait_done(0);
    c = 0;
    do begin @(negedge i_Clk); c++; end while (!o_fAbort[0] && c < 100);
    chk("abort_delay", c, 16);
    chk("abort_grant", o_Grant, 2'b00);
    push_blk(1, t_i);
    raise(1, 1'b1, t_i);
    wait_ack(1, c);
    chk("after_abort_grant", o_Grant, 2'b10);
    wait_done(1);

    // owner request lands in the timeout cycle
    push_blk(0, t_j); push_blk(0, t_k);
    raise(0, 1'b0, t_j);
    wait_ack(0, c);
    wait_done(0);
    repeat (15) @(negedge i_Clk);
    raise(0, 1'b1, t_k);
    wait_ack(0, c);
    chk("edge_ack_latency", c, 1);
    chk("edge_no_abort", o_fAbort, 2'b00);
    wait_done(0);

    // reset in the middle of a block
    core_lat = 20;
    ack_q.push_back(0);
    raise(0, 1'b1, t_l);
    wait_ack(0, c);
    repeat (5) @(negedge i_Clk);
    #1 i_Rst = 1'b1;
    #1;
    chk("midrst_ctrl", {o_Grant, o_fAck, o_fDone, o_fAbort, o_Core_fStart, o_Core_fInit}, '0);
    chk("midrst_digest", o_Digest, '0);
    chk("midrst_text", o_Core_Text, '0);
    @(negedge i_Clk);
    i_Rst = 1'b0;
    push_blk(1, t_m);
    raise(1, 1'b1, t_m);
    wait_ack(1, c);
    chk("postrst_finit", o_Core_fInit, 1'b1);
    chk("postrst_grant", o_Grant, 2'b10);
    wait_done(1);

    repeat (2) @(negedge i_Clk);
    chk("ack_q_drained", ack_q.size(), 0);
    chk("done_q_drained", done_q.size(), 0);
    chk("abort_q_drained", abort_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sha_256_arbiter.md
SHA_256_ARBITER -- requirements
Module: sha_256_arbiter

Interface
REQ-001 Parameter TIMEOUT_CYC, default 4096: maximum number of idle cycles the owner may wait between blocks of one message.
REQ-002 i_Clk  in  1  sole clock; all state changes on its rising edge.
REQ-003 i_Rst  in  1  asynchronous, active-high reset.
REQ-004 i_fReq  in  2  per-requester block request, held until o_fAck.
REQ-005 i_fLast  in  2  per-requester flag marking the final block of a message, valid with i_fReq.
REQ-006 i_Text0 / i_Text1  in  512 each  message block of requester 0 / 1, stable while i_fReq is high.
REQ-007 o_fAck  out  2  one-cycle pulse: block latched and launched.
REQ-008 o_fDone  out  2  one-cycle pulse: block hashed, and o_Digest is valid.
REQ-009 o_fAbort  out  2  one-cycle pulse: message abandoned on timeout.
REQ-010 o_Digest  out  256  registered core result, held until the next o_fDone.
REQ-011 o_Grant  out  2  one-hot owner of the core; 0 when free.
REQ-012 o_Core_fStart, o_Core_fInit  out  1 each  core start level and first-block flag.
REQ-013 o_Core_Text  out  512  latched block driven to the core.
REQ-014 i_Core_fDone  in  1  core completion pulse; i_Core_Text  in  256  core digest.

Function
REQ-015 The FSM SHALL have three states:
- IDLE: core free.
- RUN: core hashing.
- HOLD: owner locked, waiting for its next block.
REQ-016 In IDLE, any i_fReq bit set at edge N SHALL produce the following at N+1:
- winner chosen;
- o_Grant set and the text latched;
- o_fAck pulsed for the winner;
- o_Core_fInit=1;
- state moves to RUN.
REQ-017 If both requesters request in IDLE, the arbiter SHALL grant the requester named by a 1-bit round-robin pointer.
REQ-018 The pointer SHALL move to the other requester whenever a message ends, whether by its last block or by abort.
REQ-019 In RUN, o_Core_fStart SHALL be 1 and o_Core_Text/o_Core_fInit SHALL stay stable until i_Core_fDone.
REQ-020 When i_Core_fDone is seen at edge M, the following SHALL hold at M+1:
- o_Digest is loaded;
- o_fDone pulses for the owner;
- o_Core_fStart drops to 0.
REQ-021 After a RUN block completes, the next state SHALL depend on the latched i_fLast:
- last=1: go to IDLE and clear o_Grant;
- last=0: go to HOLD.
REQ-022 In HOLD, an owner request SHALL latch the block, pulse o_fAck, set o_Core_fInit=0 and enter RUN on the next cycle.
REQ-023 Any request from the non-owner SHALL be ignored in RUN and HOLD, with no o_fAck.
REQ-024 An owner request SHALL NOT be acknowledged while in RUN.
REQ-025 The HOLD timer SHALL count from 0 on entry to HOLD.
REQ-026 When the HOLD timer reaches TIMEOUT_CYC-1 with no owner request, the arbiter SHALL:
- pulse o_fAbort for the owner;
- clear o_Grant;
- enter IDLE.
REQ-027 If the owner request and the timeout fall in the same cycle, the request SHALL win and no abort SHALL occur.
REQ-028 The timer SHALL saturate at the timeout value, SHALL NOT wrap, and SHALL be sized ceil(log2(TIMEOUT_CYC)).
REQ-029 An i_Core_fDone arriving outside RUN SHALL be ignored.
REQ-030 o_fAck, o_fDone and o_fAbort SHALL each be at most one-hot and SHALL never pulse for a non-owner.

Reset
REQ-031 On i_Rst the block SHALL reset as follows, regardless of the clock:
- state to IDLE, pointer to 0, timer to 0;
- o_Grant, o_fAck, o_fDone, o_fAbort, o_Core_fStart, o_Core_fInit to 0;
- o_Digest and o_Core_Text to 0.
REQ-032 A reset during RUN SHALL drop o_Core_fStart immediately.
REQ-033 The core SHALL share i_Rst, so that no partial hash survives the reset.

Structure
REQ-034 A shared package SHALL hold:
- the state encoding (IDLE, RUN, HOLD);
- BLOCK_W=512 and DIGEST_W=256;
- the TIMEOUT_CYC default.
REQ-035 One sub-module, sha_256_rr_pick, SHALL take the 2-bit request vector and the pointer and return the one-hot winner.
REQ-036 The rest of the block SHALL be flat.

Verification
REQ-037 Scenario: req0 alone with last=1 and text=0x61626380...0018 ("abc" padded), core digest returned after 70 cycles.
- Required: o_fAck[0] one cycle after the request, fInit=1.
- Required: o_fDone[0] with o_Digest=ba7816bf...f20015ad, then IDLE.
REQ-038 Scenario: req0 and req1 asserted together from reset.
- Required: requester 0 granted first; requester 1 acked only after requester 0's o_fDone.
- Required: on the next simultaneous request, requester 1 is granted first.
REQ-039 Scenario: requester 0 sends a 2-block message (last=0, then last=1) while req1 stays high throughout.
- Required: fInit=1 then 0.
- Required: o_Grant=01 is held through HOLD, and req1 is not acked until requester 0's message ends.
REQ-040 Scenario: TIMEOUT_CYC=16, requester 0 sends a last=0 block and then goes silent.
- Required: o_fAbort[0] exactly 16 cycles after HOLD entry; o_Grant=00.
- Required: a following req1 is granted.
REQ-041 Scenario: owner request arrives in the same cycle as the timeout.
- Required: o_fAck pulses and no o_fAbort.
REQ-042 Scenario: i_Rst asserted mid-RUN.
- Required: all outputs are 0 before the next clock edge.
- Required: a new req1 after reset release is granted with fInit=1.
